// File: rtl/obstacle_scheduler_pkg.sv
// Shared definitions for the obstacle scheduler: state encoding, score bands
// that select the step period, and the direction-pattern LFSR.
package obstacle_scheduler_pkg;

  // Encoding is visible on o_State, so the values are fixed.
  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StRun      = 3'd1,
    StPause    = 3'd2,
    StFreeze   = 3'd3,
    StLevel    = 3'd4,
    StGameOver = 3'd5,
    StWin      = 3'd6
  } state_e;

  // Width of the step-period counter.
  localparam int unsigned CntWidth = 20;

  // Score thresholds where the step period halves.
  localparam logic [3:0] ScoreBand1 = 4'd4;
  localparam logic [3:0] ScoreBand2 = 4'd7;
  localparam logic [3:0] ScoreBand3 = 4'd10;

  // Feedback taps of the 4-bit direction LFSR.
  localparam int unsigned LfsrTapA = 3;
  localparam int unsigned LfsrTapB = 2;

  // One LFSR step: shift left, feed back the XOR of the two taps.
  function automatic logic [3:0] lfsr_step(input logic [3:0] value);
    return {value[2:0], value[LfsrTapA] ^ value[LfsrTapB]};
  endfunction

  // Saturating score increment; the score never wraps past 15.
  function automatic logic [3:0] score_step(input logic [3:0] score);
    return (score == 4'hF) ? 4'hF : score + 4'd1;
  endfunction

endpackage

// File: rtl/obstacle_scheduler_if.sv
// Control/status bundle between the game logic and the obstacle scheduler.
interface obstacle_scheduler_if #(
  parameter int unsigned NUM_LANES = 4
);

  logic                 i_Start;
  logic                 i_Pause;
  logic                 i_Level_Done;
  logic                 i_Collision;
  logic [2:0]           o_State;
  logic                 o_Move_Tick;
  logic [NUM_LANES-1:0] o_Reverse;
  logic [3:0]           o_Score;
  logic [1:0]           o_Lives;
  logic                 o_Game_Over;
  logic                 o_Win;

  // Game-flow side: issues events, observes scheduler status.
  modport master (
    output i_Start,
    output i_Pause,
    output i_Level_Done,
    output i_Collision,
    input  o_State,
    input  o_Move_Tick,
    input  o_Reverse,
    input  o_Score,
    input  o_Lives,
    input  o_Game_Over,
    input  o_Win
  );

  // Scheduler side.
  modport slave (
    input  i_Start,
    input  i_Pause,
    input  i_Level_Done,
    input  i_Collision,
    output o_State,
    output o_Move_Tick,
    output o_Reverse,
    output o_Score,
    output o_Lives,
    output o_Game_Over,
    output o_Win
  );

endinterface

// File: rtl/obstacle_scheduler_tick_divider.sv
// Step-period divider: picks the period from the current score and flags
// expiry on the cycle the counter reaches the end of that period.
module obstacle_scheduler_tick_divider
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned C_BASE_TICK_PERIOD = 781250
) (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic [3:0] i_Score,
  input  logic       i_Enable,
  input  logic       i_Hold,
  input  logic       i_Clear,
  output logic       o_Expire
);

  localparam logic [CntWidth-1:0] BasePeriod = CntWidth'(C_BASE_TICK_PERIOD);

  logic [CntWidth-1:0] period;
  logic [CntWidth-1:0] cnt_q;
  logic                counting;

  // Period shrinks by powers of two as the score crosses each band.
  always_comb begin
    period = BasePeriod;
    if (i_Score >= ScoreBand3) begin
      period = BasePeriod >> 3;
    end else if (i_Score >= ScoreBand2) begin
      period = BasePeriod >> 2;
    end else if (i_Score >= ScoreBand1) begin
      period = BasePeriod >> 1;
    end
  end

  assign counting = i_Enable && !i_Hold && !i_Clear;

  // ">=" rather than "==" so a count left above a freshly shrunk period
  // still expires instead of running on to wrap-around.
  assign o_Expire = counting && (({1'b0, cnt_q} + 21'd1) >= {1'b0, period});

  // Counter advances while counting, restarts at expiry, clears on request.
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      cnt_q <= '0;
    end else if (counting) begin
      cnt_q <= o_Expire ? '0 : cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/obstacle_scheduler.sv
// Game-flow controller: sequences obstacle motion steps, tracks score and
// lives, rotates the lane direction pattern between levels and freezes
// motion for a while after a collision.
module obstacle_scheduler
  import obstacle_scheduler_pkg::*;
#(
  parameter int unsigned C_BASE_TICK_PERIOD = 781250,
  parameter int unsigned NUM_LANES          = 4,
  parameter int unsigned LIVES_INIT         = 3,
  parameter int unsigned MAX_LEVEL          = 10,
  parameter int unsigned FREEZE_TICKS       = 64,
  parameter logic [3:0]  LFSR_SEED          = 4'b1010
) (
  input  logic                 i_Clk,
  input  logic                 i_Reset,
  obstacle_scheduler_if.slave  bus
);

  localparam int unsigned FreezeW = $clog2(FREEZE_TICKS + 2);

  localparam logic [1:0]           LivesInit  = 2'(LIVES_INIT);
  localparam logic [3:0]           MaxLevel   = 4'(MAX_LEVEL);
  localparam logic [FreezeW-1:0]   FreezeInit = FreezeW'(FREEZE_TICKS);
  localparam logic [FreezeW-1:0]   FreezeOne  = FreezeW'(1);
  localparam logic [NUM_LANES-1:0] SeedLanes  = LFSR_SEED[NUM_LANES-1:0];

  state_e               state_q;
  logic [3:0]           score_q;
  logic [1:0]           lives_q;
  logic [3:0]           lfsr_q;
  logic [NUM_LANES-1:0] reverse_q;
  logic                 move_tick_q;
  logic [FreezeW-1:0]   freeze_q;
  logic                 game_over_q;
  logic                 win_q;

  logic                 expire;
  logic                 div_enable;
  logic                 div_hold;
  logic                 div_clear;
  logic [3:0]           lfsr_next;
  logic [3:0]           score_inc;

  assign lfsr_next = lfsr_step(lfsr_q);
  assign score_inc = score_step(score_q);

  // Counter runs in RUN/FREEZE, holds in PAUSE and is cleared in every state
  // that re-enters RUN with a fresh period (IDLE, LEVEL, GAME_OVER, WIN).
  assign div_enable = (state_q == StRun) || (state_q == StFreeze) || (state_q == StPause);
  assign div_hold   = (state_q == StPause);
  assign div_clear  = (state_q == StIdle) || (state_q == StLevel) ||
                      (state_q == StGameOver) || (state_q == StWin);

  obstacle_scheduler_tick_divider #(
    .C_BASE_TICK_PERIOD (C_BASE_TICK_PERIOD)
  ) u_tick_divider (
    .i_Clk    (i_Clk),
    .i_Reset  (i_Reset),
    .i_Score  (score_q),
    .i_Enable (div_enable),
    .i_Hold   (div_hold),
    .i_Clear  (div_clear),
    .o_Expire (expire)
  );

  // Game FSM with score/lives/direction bookkeeping and registered outputs.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= StIdle;
      score_q     <= '0;
      lives_q     <= LivesInit;
      lfsr_q      <= LFSR_SEED;
      reverse_q   <= SeedLanes;
      move_tick_q <= 1'b0;
      freeze_q    <= '0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
    end else begin
      // Motion steps are only emitted while actually running.
      move_tick_q <= (state_q == StRun) && expire;

      unique case (state_q)
        StIdle: begin
          if (bus.i_Start) begin
            state_q <= StRun;
          end
        end

        StRun: begin
          // Collision beats level-done, which beats pause.
          if (bus.i_Collision) begin
            if (lives_q <= 2'd1) begin
              lives_q     <= '0;
              game_over_q <= 1'b1;
              state_q     <= StGameOver;
            end else begin
              lives_q  <= lives_q - 2'd1;
              freeze_q <= FreezeInit;
              state_q  <= StFreeze;
            end
          end else if (bus.i_Level_Done) begin
            score_q <= score_inc;
            if (score_inc == MaxLevel) begin
              win_q   <= 1'b1;
              state_q <= StWin;
            end else begin
              state_q <= StLevel;
            end
          end else if (bus.i_Pause) begin
            state_q <= StPause;
          end
        end

        StPause: begin
          if (!bus.i_Pause) begin
            state_q <= StRun;
          end
        end

        StFreeze: begin
          if (expire) begin
            if (freeze_q <= FreezeOne) begin
              freeze_q <= '0;
              state_q  <= StRun;
            end else begin
              freeze_q <= freeze_q - FreezeOne;
            end
          end
        end

        StLevel: begin
          lfsr_q    <= lfsr_next;
          reverse_q <= lfsr_next[NUM_LANES-1:0];
          state_q   <= StRun;
        end

        StGameOver, StWin: begin
          // Restart skips IDLE and goes straight back into play.
          if (bus.i_Start) begin
            score_q     <= '0;
            lives_q     <= LivesInit;
            lfsr_q      <= LFSR_SEED;
            reverse_q   <= SeedLanes;
            game_over_q <= 1'b0;
            win_q       <= 1'b0;
            state_q     <= StRun;
          end
        end

        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign bus.o_State     = state_q;
  assign bus.o_Move_Tick = move_tick_q;
  assign bus.o_Reverse   = reverse_q;
  assign bus.o_Score     = score_q;
  assign bus.o_Lives     = lives_q;
  assign bus.o_Game_Over = game_over_q;
  assign bus.o_Win       = win_q;

endmodule
